// File: rtl/light_pkg.sv
// Shared definitions for the traffic-light timing path: phase select codes,
// default durations and the configuration FSM encoding.
package light_pkg;

    localparam int LIGHT_DUR_W   = 4;
    localparam int LIGHT_DUR_MAX = 9;
    localparam int LIGHT_DEF_G   = 4;
    localparam int LIGHT_DEF_Y   = 0;
    localparam int LIGHT_DEF_R   = 0;

    localparam logic [1:0] SEL_RUN = 2'b00;
    localparam logic [1:0] SEL_Y   = 2'b01;
    localparam logic [1:0] SEL_G   = 2'b10;
    localparam logic [1:0] SEL_R   = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_EDIT   = 2'd1,
        ST_COMMIT = 2'd2
    } cfg_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Single-button debouncer: a raw level must hold for DEB_CYCLES cycles before it
// becomes the stable level; a 0->1 change of the stable level yields a one-cycle press.
module btn_debounce #(
    parameter int DEB_CYCLES = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);

    logic             raw_q;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            raw_q <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            raw_q <= raw;
            press <= 1'b0;
            if (raw != raw_q) begin
                cnt <= '0;
            end else if (cnt != CNT_W'(DEB_CYCLES)) begin
                cnt <= cnt + 1'b1;
                // The counter parks at DEB_CYCLES, so a held button never re-fires.
                if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
                    level <= raw_q;
                    press <= raw_q & ~level;
                end
            end
        end
    end

endmodule

// File: rtl/light_timing_cfg.sv
// Operator-side editor for traffic-light phase durations: debounced buttons edit a
// shadow copy of the durations, and a commit copies the shadows to the sequencer.
module light_timing_cfg
    import light_pkg::*;
#(
    parameter int DEB_CYCLES = 20,
    parameter int DUR_W      = LIGHT_DUR_W,
    parameter int DUR_MAX    = LIGHT_DUR_MAX,
    parameter int DEF_G      = LIGHT_DEF_G,
    parameter int DEF_Y      = LIGHT_DEF_Y,
    parameter int DEF_R      = LIGHT_DEF_R
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       sw,
    input  logic [3:0]       btn,
    output logic [DUR_W-1:0] dur_g,
    output logic [DUR_W-1:0] dur_y,
    output logic [DUR_W-1:0] dur_r,
    output logic             cfg_upd,
    output logic             editing,
    output logic [3:0]       led
);

    logic [3:0] press;
    logic [3:0] btn_level_unused;

    for (genvar i = 0; i < 4; i++) begin : g_deb
        btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk   (clk),
            .rst   (rst),
            .raw   (btn[i]),
            .level (btn_level_unused[i]),
            .press (press[i])
        );
    end

    // Restore beats dec beats inc; commit is resolved by the FSM before any edit.
    function automatic logic [DUR_W-1:0] edit_val(input logic [DUR_W-1:0] cur,
                                                  input logic [DUR_W-1:0] def,
                                                  input logic [3:0]       ev);
        if (ev[2])
            return def;
        else if (ev[1])
            return (cur == '0) ? '0 : cur - 1'b1;
        else if (ev[0])
            return (int'(cur) >= DUR_MAX) ? DUR_W'(DUR_MAX) : cur + 1'b1;
        return cur;
    endfunction

    function automatic logic [3:0] led_of(input logic [DUR_W-1:0] v);
        int s;
        s = int'(v) + 1;
        return (s > 15) ? 4'd15 : 4'(s);
    endfunction

    cfg_state_t       state, state_nxt;
    logic [DUR_W-1:0] sh_g, sh_y, sh_r;
    logic [DUR_W-1:0] sh_g_nxt, sh_y_nxt, sh_r_nxt, sel_nxt;
    logic [3:0]       led_nxt;
    logic             commit_p1;

    always_comb begin
        state_nxt = state;
        sh_g_nxt  = sh_g;
        sh_y_nxt  = sh_y;
        sh_r_nxt  = sh_r;
        case (state)
            ST_RUN: begin
                sh_g_nxt = dur_g;
                sh_y_nxt = dur_y;
                sh_r_nxt = dur_r;
                if (sw != SEL_RUN) state_nxt = ST_EDIT;
            end
            ST_EDIT: begin
                if (sw == SEL_RUN) begin
                    state_nxt = ST_RUN;
                end else if (press[3]) begin
                    state_nxt = ST_COMMIT;
                end else begin
                    case (sw)
                        SEL_Y:   sh_y_nxt = edit_val(sh_y, DUR_W'(DEF_Y), press);
                        SEL_G:   sh_g_nxt = edit_val(sh_g, DUR_W'(DEF_G), press);
                        default: sh_r_nxt = edit_val(sh_r, DUR_W'(DEF_R), press);
                    endcase
                end
            end
            ST_COMMIT: state_nxt = (sw == SEL_RUN) ? ST_RUN : ST_EDIT;
            default:   state_nxt = ST_RUN;
        endcase

        case (sw)
            SEL_Y:   sel_nxt = sh_y_nxt;
            SEL_G:   sel_nxt = sh_g_nxt;
            SEL_R:   sel_nxt = sh_r_nxt;
            default: sel_nxt = '0;
        endcase
        led_nxt = (state_nxt == ST_RUN) ? 4'd0 : led_of(sel_nxt);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_RUN;
            dur_g     <= DUR_W'(DEF_G);
            dur_y     <= DUR_W'(DEF_Y);
            dur_r     <= DUR_W'(DEF_R);
            sh_g      <= DUR_W'(DEF_G);
            sh_y      <= DUR_W'(DEF_Y);
            sh_r      <= DUR_W'(DEF_R);
            commit_p1 <= 1'b0;
            cfg_upd   <= 1'b0;
            editing   <= 1'b0;
            led       <= 4'd0;
        end else begin
            state    <= state_nxt;
            sh_g     <= sh_g_nxt;
            sh_y     <= sh_y_nxt;
            sh_r     <= sh_r_nxt;
            if (state == ST_COMMIT) begin
                dur_g <= sh_g;
                dur_y <= sh_y;
                dur_r <= sh_r;
            end
            // cfg_upd trails the dur_* update by one cycle so readers see settled values.
            commit_p1 <= (state == ST_COMMIT);
            cfg_upd   <= commit_p1;
            editing   <= (state_nxt == ST_EDIT);
            led       <= led_nxt;
        end
    end

endmodule

// File: tb/tb_light_timing_cfg.sv
// Scoreboard bench for light_timing_cfg: a phase-level model predicts led changes
// and committed duration triples; a monitor compares them as the DUT produces them.
module tb_light_timing_cfg;

    localparam int DEB  = 4;
    localparam int DMAX = 9;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] sw  = 2'b00;
    logic [3:0] btn = 4'b0000;
    logic [3:0] dur_g, dur_y, dur_r;
    logic       cfg_upd, editing;
    logic [3:0] led;

    light_timing_cfg #(.DEB_CYCLES(DEB)) dut (
        .clk     (clk),
        .rst     (rst),
        .sw      (sw),
        .btn     (btn),
        .dur_g   (dur_g),
        .dur_y   (dur_y),
        .dur_r   (dur_r),
        .cfg_upd (cfg_upd),
        .editing (editing),
        .led     (led)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state, indexed by phase select code: 1 = yellow, 2 = green, 3 = red.
    int m_dur[4];
    int m_sh[4];
    int m_def[4];
    int m_sel  = 0;
    bit m_edit = 0;
    int m_led  = 0;

    int led_q[$];
    int cfg_q[$];
    bit mon_en   = 0;
    int prev_led = 0;

    function automatic int pack3(input int g, input int y, input int r);
        return g * 256 + y * 16 + r;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic model_led_update();
        int nl;
        nl = 0;
        if (m_edit) nl = (m_sh[m_sel] + 1 > 15) ? 15 : m_sh[m_sel] + 1;
        if (nl != m_led) begin
            led_q.push_back(nl);
            m_led = nl;
        end
    endtask

    task automatic model_defaults();
        m_def[0] = 0; m_def[1] = 0; m_def[2] = 4; m_def[3] = 0;
        m_dur = m_def;
        m_sh  = m_def;
        m_edit = 0;
    endtask

    task automatic set_sw(input int v);
        @(negedge clk);
        sw = 2'(v);
        if (v == 0) begin
            m_edit = 0;
            m_sh   = m_dur;
        end else begin
            m_edit = 1;
            m_sel  = v;
        end
        model_led_update();
        repeat (3) @(negedge clk);
    endtask

    // Simultaneous bits in mask are debounced together and land in the same cycle.
    task automatic model_event(input int mask);
        if (!m_edit) return;
        if (mask[3]) begin
            m_dur = m_sh;
            cfg_q.push_back(pack3(m_dur[2], m_dur[1], m_dur[3]));
        end else if (mask[2]) begin
            m_sh[m_sel] = m_def[m_sel];
        end else if (mask[1]) begin
            if (m_sh[m_sel] > 0) m_sh[m_sel]--;
        end else if (mask[0]) begin
            if (m_sh[m_sel] < DMAX) m_sh[m_sel]++;
        end
        model_led_update();
    endtask

    task automatic press(input int mask);
        @(negedge clk);
        btn = 4'(mask);
        model_event(mask);
        repeat (DEB + 4) @(negedge clk);
        btn = 4'b0000;
        repeat (DEB + 4) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        sw  = 2'b00;
        btn = 4'b0000;
        model_defaults();
        model_led_update();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_dur_g"},   int'(dur_g),   4);
        check({tag, "_dur_y"},   int'(dur_y),   0);
        check({tag, "_dur_r"},   int'(dur_r),   0);
        check({tag, "_cfg_upd"}, int'(cfg_upd), 0);
        check({tag, "_led"},     int'(led),     0);
        check({tag, "_editing"}, int'(editing), 0);
    endtask

    // Monitor: every led change and every cfg_upd pulse must match the next prediction.
    always @(negedge clk) begin
        if (mon_en) begin
            if (int'(led) != prev_led) begin
                if (led_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL led_event: got %0d, expected no change from %0d", led, prev_led);
                end else begin
                    check("led_event", int'(led), led_q.pop_front());
                end
                prev_led = int'(led);
            end
            if (cfg_upd) begin
                if (cfg_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL cfg_upd_event: got unexpected pulse with g/y/r %0d/%0d/%0d",
                             dur_g, dur_y, dur_r);
                end else begin
                    check("cfg_commit_gyr", pack3(int'(dur_g), int'(dur_y), int'(dur_r)),
                          cfg_q.pop_front());
                end
            end
        end
    end

    initial begin
        int masks[8];
        masks = '{1, 2, 4, 8, 1, 2, 3, 12};
        model_defaults();

        // Power-on reset.
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("reset");
        prev_led = int'(led);
        mon_en   = 1;

        // Bounce on inc: short pulses are rejected, the final hold yields one inc.
        set_sw(2);
        for (int i = 0; i < 6; i++) begin
            btn[0] = ~btn[0];
            repeat (2) @(negedge clk);
        end
        btn[0] = 1'b1;
        model_event(1);
        repeat (10) @(negedge clk);
        btn[0] = 1'b0;
        repeat (DEB + 4) @(negedge clk);
        check("bounce_led", int'(led), 6);
        check("bounce_dur_g_uncommitted", int'(dur_g), 4);
        check("bounce_editing", int'(editing), 1);

        // Saturation at both ends.
        for (int i = 0; i < 7; i++) press(1);
        check("sat_high_led", int'(led), 10);
        set_sw(1);
        for (int i = 0; i < 3; i++) press(2);
        check("sat_low_led", int'(led), 1);

        // Commit green 9 / yellow 0.
        press(8);
        check("commit_dur_g", int'(dur_g), 9);
        check("commit_dur_y", int'(dur_y), 0);

        // Leaving edit discards uncommitted red edits.
        set_sw(3);
        press(1);
        press(1);
        check("discard_led_before", int'(led), 3);
        set_sw(0);
        check("discard_dur_r", int'(dur_r), 0);
        check("discard_editing", int'(editing), 0);
        set_sw(3);
        check("discard_led_after", int'(led), 1);

        // Commit and inc debounced together: commit wins, inc is dropped.
        press(1);
        press(9);
        check("prio_led", int'(led), 2);
        check("prio_dur_r", int'(dur_r), 1);

        // Reset in the middle of an edit restores defaults everywhere.
        press(1);
        do_reset();
        check_reset_state("midreset");
        set_sw(3);
        check("midreset_led_r", int'(led), 1);
        set_sw(2);
        check("midreset_led_g", int'(led), 5);

        // Randomized phase: sw moves and single or combined button events.
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 9) < 2) set_sw(int'($urandom_range(0, 3)));
            else press(masks[$urandom_range(0, 7)]);
        end
        set_sw(2);
        press(8);

        repeat (10) @(negedge clk);
        check("led_queue_drained", led_q.size(), 0);
        check("cfg_queue_drained", cfg_q.size(), 0);
        check("final_dur_g", int'(dur_g), m_dur[2]);
        check("final_dur_y", int'(dur_y), m_dur[1]);
        check("final_dur_r", int'(dur_r), m_dur[3]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
